pipelined_alu: RTL

//   Parametrised 2-stage pipelined ALU, the registered successor of the combinational ALU.
//   - 4-bit opcode space with variable shifts and a carry-chained add/sub via an internal carry register.
//   - Full flag set: zero, negative, carry, overflow and illegal-op.
//   - valid/ready handshake on both sides; sits between an instruction sequencer and a result sink.

---
 rtl/pipelined_alu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage pipelined ALU with a valid/ready handshake on both sides.
//   Stage 1 registers the operands and opcode. The result and flags are computed
//   combinationally from stage 1 and loaded into the output stage (stage 2).
//   An internal carry register (carry_q) chains ADD/SUB/ADDC/SUBC/CLRC.
// Optional feature macro: ALU_MUL_EN -- when defined, op 12 is MUL (low WIDTH bits
//   of a*b). When undefined, op 12 is reserved and no multiplier is built.
// Parameters:
//   WIDTH    operand/result width (>=2); shift amount is b[$clog2(WIDTH)-1:0]
//   CARRY_RV reset value of carry_q
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input beat handshake carrying a, b, op
//   out_valid/out_ready   output beat handshake carrying result and flags
//   result                ALU result
//   flag_z/n/c/v/ill      zero, negative, carry_q after op, signed overflow, illegal op
module pipelined_alu #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        CARRY_RV = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_ill
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SRA   = 4'd8,
    OP_ADDC  = 4'd9,
    OP_SUBC  = 4'd10,
    OP_SLTU  = 4'd11,
    OP_MUL   = 4'd12,
    OP_PASSB = 4'd13,
    OP_CLRC  = 4'd14,
    OP_RSVD  = 4'd15
  } op_e;

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic carry_q;

  // Handshake control
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = rst_n && (!s1_valid || s1_adv);
  assign in_fire  = in_valid && in_ready;

  // Combinational compute from stage 1
  logic [SHW-1:0]   sh;
  logic             cin;
  logic             bin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic             v_add;
  logic             v_sub;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic             ill_d;

  assign sh  = s1_b[SHW-1:0];
  assign cin = (s1_op == OP_ADDC) ? carry_q : 1'b0;
  assign bin = (s1_op == OP_SUBC) ? carry_q : 1'b0;

  // Extended by one bit so the top bit is the carry out (add) or the borrow (sub):
  // a subtraction that goes below zero wraps into the upper half of the WIDTH+1 range.
  assign sum_ext = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, cin};
  assign dif_ext = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, bin};

  assign v_add = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_ext[WIDTH-1] != s1_a[WIDTH-1]);
  assign v_sub = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (dif_ext[WIDTH-1] != s1_a[WIDTH-1]);

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mul_lo;
  assign mul_lo = s1_a * s1_b;
`endif

  always_comb begin
    res_d = '0;
    c_d   = carry_q;
    v_d   = 1'b0;
    ill_d = 1'b0;
    case (s1_op)
      OP_ADD, OP_ADDC: begin
        res_d = sum_ext[WIDTH-1:0];
        c_d   = sum_ext[WIDTH];
        v_d   = v_add;
      end
      OP_SUB, OP_SUBC: begin
        res_d = dif_ext[WIDTH-1:0];
        c_d   = dif_ext[WIDTH];
        v_d   = v_sub;
      end
      OP_AND:   res_d = s1_a & s1_b;
      OP_OR:    res_d = s1_a | s1_b;
      OP_XOR:   res_d = s1_a ^ s1_b;
      OP_NOT:   res_d = ~s1_a;
      OP_SHL:   res_d = s1_a << sh;
      OP_SHR:   res_d = s1_a >> sh;
      OP_SRA:   res_d = $unsigned($signed(s1_a) >>> sh);
      OP_SLTU:  res_d = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
`ifdef ALU_MUL_EN
      OP_MUL:   res_d = mul_lo;
`endif
      OP_PASSB: res_d = s1_b;
      OP_CLRC: begin
        res_d = '0;
        c_d   = 1'b0;
      end
      default: begin
        res_d = '0;
        ill_d = 1'b1;
      end
    endcase
  end

  // Stage 1: load on input handshake, empty when it advances without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s1_adv);
      if (in_fire) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(op);
      end
    end
  end

  // Stage 2 and carry register. carry_q updates in the same cycle the op moves
  // into stage 2, so a following ADDC/SUBC in stage 1 sees it without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_ill  <= 1'b0;
      carry_q   <= CARRY_RV;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        result    <= res_d;
        flag_z    <= (res_d == '0);
        flag_n    <= res_d[WIDTH-1];
        flag_c    <= c_d;
        flag_v    <= v_d;
        flag_ill  <= ill_d;
        carry_q   <= c_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
